ap_ctrl_txn_tracker: RTL and testbench
======================================

// Module: ap_ctrl_txn_tracker
// PURPOSE
//  Synthesizable per-kernel transaction tracker that sits upstream of the CSV status dumpers.
//  It watches one ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_continue) of a
//  myproject sub-kernel, for example pairwise_dist_sq_rbf or mask_and_normalize.
//  It emits one record per completed transaction: id, start timestamp, latency and initiation interval.
//  It also keeps busy, stall and drop counters, so that the monitor/dumper stage consumes records instead of raw strobes.
// PARAMETERS
//  TS_W            32  timestamp/latency width; arithmetic is modulo 2^TS_W
//  ID_W            16  transaction id width; wraps modulo 2^ID_W
//  CNT_W           32  width of busy/stall/drop counters; counters saturate at all-ones
//  MAX_OUTSTANDING 4   start-timestamp FIFO depth (power of two, >=2)
// PORTS
//  clock        in   1       single clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  ap_start     in   1       observed kernel start
//  ap_ready     in   1       observed kernel ready; ap_start&&ap_ready = accept
//  ap_done      in   1       observed kernel done
//  ap_continue  in   1       observed continue; tie 1'b1 for non-dataflow kernels
//  finish       in   1       end of simulation/run request
//  rec_valid    out  1       record available
//  rec_ready    in   1       downstream dumper accepts record
//  rec_id       out  ID_W    accept-order id of completed transaction
//  rec_start    out  TS_W    timestamp of the accept cycle
//  rec_latency  out  TS_W    completion ts minus accept ts
//  rec_ii       out  TS_W    this start ts minus the previous accepted start ts; 0 for the first record
//  outstanding  out  clog2(MAX_OUTSTANDING)+1  accepted, not yet completed
//  busy_cycles  out  CNT_W   cycles in BUSY or DONE_WAIT
//  stall_cycles out  CNT_W   cycles in DONE_WAIT
//  drop_count   out  CNT_W   records lost to backpressure plus orphan completions
//  ts_overflow  out  1       sticky: accept occurred while the start FIFO was full
//  flushed      out  1       finish seen, nothing outstanding, no record pending
// BEHAVIOUR
//  - Reset: every output is 0, ts=0, FIFO empty, state IDLE, finish latch cleared. Reset mid-operation discards all state.
//  - ts is a free-running counter: +1 per cycle from 0 after reset, wraps modulo 2^TS_W.
//  - Accept (start&&ready, finish latch clear):
//      - push {ts, id_ctr, ts-last_start} into the FIFO; id_ctr++; last_start=ts.
//      - If the FIFO is full: no push, ts_overflow<=1, id_ctr still increments.
//  - Completion (done&&continue):
//      - Pop the head and form a record with latency = ts - head.start.
//      - FIFO empty -> orphan: no record, drop_count++.
//  - Same-cycle accept and completion: the pop is evaluated before the push.
//      - With an empty FIFO the completion is an orphan and the accept is pushed.
//      - A full FIFO plus a completion does not overflow.
//  - Output register: the record appears the cycle after completion.
//      - If rec_valid&&!rec_ready when a new record forms: new record dropped, drop_count++, held record unchanged.
//      - If rec_valid&&rec_ready in the same cycle: the new record replaces it with no drop.
//  - FSM (registered, evaluated from next-cycle values):
//      - IDLE: outstanding==0.
//      - BUSY: outstanding>0.
//      - DONE_WAIT: ap_done && !ap_continue; has priority over BUSY.
//      - FLUSHED: finish latch set && outstanding==0 && !rec_valid. Terminal until reset; flushed=1 only here.
//  - finish: latched sticky. Later accepts are ignored (no push, no id increment). Completions are still tracked.
//  - Counters: busy_cycles +1 per cycle in BUSY/DONE_WAIT; stall_cycles +1 per cycle in DONE_WAIT. All saturate.
//  - Width rules: all ts differences are unsigned modulo 2^TS_W. No sign extension.
// TESTING
//  1. Accept at ts5, done at ts12, rec_ready=1 -> rec_valid at ts13: id0, start5, latency7, ii0; busy_cycles=7.
//  2. Accepts at ts10,12,14, dones at ts20,22,24 -> ids0/1/2, latency 10 each, ii 0/2/2; outstanding peaks at 3.
//  3. rec_ready=0, two completions -> first record held, second dropped, drop_count=1; rec_ready=1 -> first record pops.
//  4. MAX_OUTSTANDING=4, 5 accepts with no done -> outstanding=4, ts_overflow=1.
//     Then 5 dones -> 4 records, drop_count=1.
//  5. ap_done high with ap_continue low for 3 cycles, then ap_continue=1 -> stall_cycles=3.
//     Single record, latency counted to the continue cycle.
//  6. TS_W=8, accept at ts250, done at ts4 -> latency 10.
//     finish with 1 outstanding -> flushed only after the done and after the record is consumed.
//     Reset while BUSY -> all outputs 0.

Source files
------------

// File: rtl/ap_ctrl_txn_tracker_if.sv
// Handshake and record bus for the ap_ctrl transaction tracker.
// The slave side is the tracker itself: it observes the kernel's
// ap_ctrl_hs strobes and the run-finish request, and sources records
// towards the downstream dumper. The master side is the environment.
interface ap_ctrl_txn_tracker_if #(
  parameter int TS_W = 32,
  parameter int ID_W = 16
);
  logic            ap_start;
  logic            ap_ready;
  logic            ap_done;
  logic            ap_continue;
  logic            finish;
  logic            rec_valid;
  logic            rec_ready;
  logic [ID_W-1:0] rec_id;
  logic [TS_W-1:0] rec_start;
  logic [TS_W-1:0] rec_latency;
  logic [TS_W-1:0] rec_ii;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_id, rec_start, rec_latency, rec_ii
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_id, rec_start, rec_latency, rec_ii
  );
endinterface

// File: rtl/ap_ctrl_txn_tracker.sv
// Per-kernel transaction tracker: turns ap_ctrl_hs strobes into one record
// per completed transaction (id, start ts, latency, initiation interval)
// and keeps saturating busy/stall/drop counters.
module ap_ctrl_txn_tracker #(
  parameter int TS_W            = 32,
  parameter int ID_W            = 16,
  parameter int CNT_W           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  ap_ctrl_txn_tracker_if.slave               bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [CNT_W-1:0]                   busy_cycles,
  output logic [CNT_W-1:0]                   stall_cycles,
  output logic [CNT_W-1:0]                   drop_count,
  output logic                               ts_overflow,
  output logic                               flushed
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int OUT_W = PTR_W + 1;
  localparam logic [OUT_W-1:0] FULL = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE_WAIT, S_FLUSHED} state_t;

  state_t state_reg, state_next;

  logic [TS_W-1:0]  ts_reg, last_start_reg;
  logic [ID_W-1:0]  id_ctr_reg;
  logic             has_prev_reg, fin_reg;
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [OUT_W-1:0] count_reg;
  logic             rec_valid_reg, ovf_reg;
  logic [ID_W-1:0]  rec_id_reg;
  logic [TS_W-1:0]  rec_start_reg, rec_latency_reg, rec_ii_reg;
  logic [CNT_W-1:0] busy_reg, stall_reg, drop_reg;

  // Start-timestamp FIFO storage; contents need no reset, only the pointers.
  logic [TS_W-1:0] fifo_start [MAX_OUTSTANDING];
  logic [ID_W-1:0] fifo_id    [MAX_OUTSTANDING];
  logic [TS_W-1:0] fifo_ii    [MAX_OUTSTANDING];

  logic             accept, complete, pop, push, orphan;
  logic             hold_drop, load, drop_evt, overflow_evt;
  logic             rec_valid_next, fin_next;
  logic [OUT_W-1:0] count_after_pop, count_next;
  logic [TS_W-1:0]  push_ii;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Event decode: pop is resolved before push so a full FIFO can accept
  // in the same cycle as a completion frees a slot.
  always_comb begin
    accept          = bus.ap_start && bus.ap_ready && !fin_reg;
    complete        = bus.ap_done && bus.ap_continue;
    pop             = complete && (count_reg != '0);
    orphan          = complete && (count_reg == '0);
    count_after_pop = count_reg - OUT_W'(pop);
    push            = accept && (count_after_pop != FULL);
    overflow_evt    = accept && !push;
    count_next      = count_after_pop + OUT_W'(push);
    push_ii         = has_prev_reg ? (ts_reg - last_start_reg) : '0;
    hold_drop       = pop && rec_valid_reg && !bus.rec_ready;
    load            = pop && !hold_drop;
    drop_evt        = orphan || hold_drop;
    fin_next        = fin_reg || bus.finish;
    rec_valid_next  = rec_valid_reg;
    if (load)
      rec_valid_next = 1'b1;
    else if (bus.rec_ready)
      rec_valid_next = 1'b0;
  end

  // Next state from next-cycle occupancy; FLUSHED is terminal until reset.
  always_comb begin
    state_next = state_reg;
    if (state_reg != S_FLUSHED) begin
      if (fin_next && (count_next == '0) && !rec_valid_next)
        state_next = S_FLUSHED;
      else if (bus.ap_done && !bus.ap_continue)
        state_next = S_DONE_WAIT;
      else if (count_next != '0)
        state_next = S_BUSY;
      else
        state_next = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // FIFO entry write on push.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_start[wr_ptr_reg] <= ts_reg;
      fifo_id[wr_ptr_reg]    <= id_ctr_reg;
      fifo_ii[wr_ptr_reg]    <= push_ii;
    end
  end

  // Timestamp, FIFO bookkeeping, record register and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_reg          <= '0;
      last_start_reg  <= '0;
      id_ctr_reg      <= '0;
      has_prev_reg    <= 1'b0;
      fin_reg         <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      rec_valid_reg   <= 1'b0;
      rec_id_reg      <= '0;
      rec_start_reg   <= '0;
      rec_latency_reg <= '0;
      rec_ii_reg      <= '0;
      ovf_reg         <= 1'b0;
      busy_reg        <= '0;
      stall_reg       <= '0;
      drop_reg        <= '0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);
      if (accept) begin
        id_ctr_reg     <= id_ctr_reg + ID_W'(1);
        last_start_reg <= ts_reg;
        has_prev_reg   <= 1'b1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      if (overflow_evt) ovf_reg <= 1'b1;
      fin_reg       <= fin_next;
      rec_valid_reg <= rec_valid_next;
      if (load) begin
        rec_id_reg      <= fifo_id[rd_ptr_reg];
        rec_start_reg   <= fifo_start[rd_ptr_reg];
        rec_latency_reg <= ts_reg - fifo_start[rd_ptr_reg];
        rec_ii_reg      <= fifo_ii[rd_ptr_reg];
      end
      if (drop_evt) drop_reg <= sat_inc(drop_reg);
      if (state_reg == S_BUSY || state_reg == S_DONE_WAIT) busy_reg <= sat_inc(busy_reg);
      if (state_reg == S_DONE_WAIT) stall_reg <= sat_inc(stall_reg);
    end
  end

  assign bus.rec_valid   = rec_valid_reg;
  assign bus.rec_id      = rec_id_reg;
  assign bus.rec_start   = rec_start_reg;
  assign bus.rec_latency = rec_latency_reg;
  assign bus.rec_ii      = rec_ii_reg;
  assign outstanding     = count_reg;
  assign busy_cycles     = busy_reg;
  assign stall_cycles    = stall_reg;
  assign drop_count      = drop_reg;
  assign ts_overflow     = ovf_reg;
  assign flushed         = (state_reg == S_FLUSHED);
endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// Bench for ap_ctrl_txn_tracker: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_ap_ctrl_txn_tracker;
  localparam int TS_W = 8;
  localparam int ID_W = 8;
  localparam int CNT_W = 10;
  localparam int MAXO = 4;
  localparam int unsigned TSM = 255;
  localparam int unsigned IDM = 255;
  localparam int unsigned CNTMAX = 1023;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]       outstanding;
  logic [CNT_W-1:0] busy_cycles, stall_cycles, drop_count;
  logic             ts_overflow, flushed;

  ap_ctrl_txn_tracker_if #(.TS_W(TS_W), .ID_W(ID_W)) bus ();

  ap_ctrl_txn_tracker #(.TS_W(TS_W), .ID_W(ID_W), .CNT_W(CNT_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clk), .reset(reset), .bus(bus), .outstanding(outstanding),
    .busy_cycles(busy_cycles), .stall_cycles(stall_cycles), .drop_count(drop_count),
    .ts_overflow(ts_overflow), .flushed(flushed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (ts %0d)", tag, got, exp, m_ts);
    end
  endtask

  // Reference model: a queue of pending transactions and the rules for
  // records, counters and run status, advanced once per clock.
  typedef struct { int unsigned start; int unsigned id; int unsigned ii; } ent_t;
  ent_t q[$];
  int unsigned m_ts, m_id, m_last, m_rid, m_rstart, m_rlat, m_rii, m_drop, m_busy, m_stall;
  bit m_has_prev, m_fin, m_rv, m_ovf, m_flushed, m_busy_flag, m_stall_flag;
  int rec_seen;

  task automatic model_step(input bit s, r, d, c, f, rr, rs);
    ent_t e;
    bit new_rec;
    int unsigned n_id, n_start, n_lat, n_ii;
    if (rs) begin
      q.delete();
      m_ts = 0; m_id = 0; m_last = 0; m_has_prev = 0; m_fin = 0; m_rv = 0;
      m_rid = 0; m_rstart = 0; m_rlat = 0; m_rii = 0; m_drop = 0; m_busy = 0;
      m_stall = 0; m_ovf = 0; m_flushed = 0; m_busy_flag = 0; m_stall_flag = 0;
      return;
    end
    new_rec = 0; n_id = 0; n_start = 0; n_lat = 0; n_ii = 0;
    if (d && c) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        new_rec = 1; n_id = e.id; n_start = e.start; n_ii = e.ii;
        n_lat = (m_ts - e.start) & TSM;
      end else if (m_drop < CNTMAX) m_drop++;
    end
    if (s && r && !m_fin) begin
      if (q.size() < MAXO) begin
        e.start = m_ts; e.id = m_id;
        e.ii = m_has_prev ? ((m_ts - m_last) & TSM) : 0;
        q.push_back(e);
      end else m_ovf = 1;
      m_id = (m_id + 1) & IDM;
      m_last = m_ts;
      m_has_prev = 1;
    end
    if (new_rec) begin
      if (m_rv && !rr) begin
        if (m_drop < CNTMAX) m_drop++;
      end else begin
        m_rv = 1; m_rid = n_id; m_rstart = n_start; m_rlat = n_lat; m_rii = n_ii;
      end
    end else if (rr) m_rv = 0;
    if (m_busy_flag && m_busy < CNTMAX) m_busy++;
    if (m_stall_flag && m_stall < CNTMAX) m_stall++;
    m_fin = m_fin || f;
    if (!m_flushed && m_fin && q.size() == 0 && !m_rv) m_flushed = 1;
    if (m_flushed) begin
      m_busy_flag = 0; m_stall_flag = 0;
    end else begin
      m_stall_flag = d && !c;
      m_busy_flag = m_stall_flag || (q.size() > 0);
    end
    m_ts = (m_ts + 1) & TSM;
  endtask

  task automatic check_all();
    check_eq("rec_valid", bus.rec_valid, m_rv);
    if (m_rv) begin
      check_eq("rec_id", bus.rec_id, m_rid);
      check_eq("rec_start", bus.rec_start, m_rstart);
      check_eq("rec_latency", bus.rec_latency, m_rlat);
      check_eq("rec_ii", bus.rec_ii, m_rii);
    end
    check_eq("outstanding", outstanding, q.size());
    check_eq("busy_cycles", busy_cycles, m_busy);
    check_eq("stall_cycles", stall_cycles, m_stall);
    check_eq("drop_count", drop_count, m_drop);
    check_eq("ts_overflow", ts_overflow, m_ovf);
    check_eq("flushed", flushed, m_flushed);
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit s, r, d, c, f, rr, rs);
    bus.ap_start = s; bus.ap_ready = r; bus.ap_done = d; bus.ap_continue = c;
    bus.finish = f; bus.rec_ready = rr; reset = rs;
    model_step(s, r, d, c, f, rr, rs);
    @(negedge clk);
    check_all();
    if (bus.rec_valid) rec_seen++;
  endtask

  task automatic idle(input bit rr);
    cycle(0, 0, 0, 1, 0, rr, 0);
  endtask

  task automatic idle_until(input int unsigned t);
    for (int i = 0; i < 300 && m_ts != t; i++) idle(1);
    check_eq("ts_reach", m_ts, t);
  endtask

  task automatic random_run(input int n, input bit allow_rst);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, 0,
            $urandom_range(0, 99) < 70, allow_rst && ($urandom_range(0, 599) == 0));
  endtask

  task automatic drain();
    cycle(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 200 && flushed !== 1'b1; i++) cycle(0, 0, 1, 1, 0, 1, 0);
    check_eq("drain_flushed", flushed, 1);
  endtask

  initial begin
    bus.ap_start = 0; bus.ap_ready = 0; bus.ap_done = 0; bus.ap_continue = 1;
    bus.finish = 0; bus.rec_ready = 1; reset = 1;
    rec_seen = 0;
    @(negedge clk);

    // Single transaction: accept at ts5, done at ts12.
    cycle(0, 0, 0, 1, 0, 1, 1);
    check_eq("reset_rec_valid", bus.rec_valid, 0);
    check_eq("reset_busy", busy_cycles, 0);
    idle_until(5);
    cycle(1, 1, 0, 1, 0, 1, 0);
    idle_until(12);
    cycle(0, 0, 1, 1, 0, 1, 0);
    check_eq("t1_valid", bus.rec_valid, 1);
    check_eq("t1_id", bus.rec_id, 0);
    check_eq("t1_start", bus.rec_start, 5);
    check_eq("t1_latency", bus.rec_latency, 7);
    check_eq("t1_ii", bus.rec_ii, 0);
    check_eq("t1_busy", busy_cycles, 7);

    // Pipelined: accepts at 10/12/14, dones at 20/22/24.
    cycle(0, 0, 0, 1, 0, 1, 1);
    idle_until(10);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 1, 0, 1, 0);
      if (k < 2) idle(1);
    end
    check_eq("t2_outstanding", outstanding, 3);
    idle_until(20);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, 1, 0, 1, 0);
      check_eq("t2_id", bus.rec_id, k);
      check_eq("t2_latency", bus.rec_latency, 10);
      check_eq("t2_ii", bus.rec_ii, (k == 0) ? 0 : 2);
      idle(1);
    end

    // Backpressure: second record dropped, first held.
    cycle(0, 0, 0, 1, 0, 1, 1);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    check_eq("t3_drop", drop_count, 1);
    check_eq("t3_held_id", bus.rec_id, 0);
    idle(1);
    check_eq("t3_popped", bus.rec_valid, 0);

    // Overflow: 5 accepts into a depth-4 FIFO, then 5 dones.
    cycle(0, 0, 0, 1, 0, 1, 1);
    repeat (5) cycle(1, 1, 0, 1, 0, 1, 0);
    check_eq("t4_outstanding", outstanding, 4);
    check_eq("t4_overflow", ts_overflow, 1);
    rec_seen = 0;
    repeat (5) cycle(0, 0, 1, 1, 0, 1, 0);
    idle(1);
    check_eq("t4_records", rec_seen, 4);
    check_eq("t4_drop", drop_count, 1);

    // Stall: done held without continue for 3 cycles.
    cycle(0, 0, 0, 1, 0, 1, 1);
    cycle(1, 1, 0, 1, 0, 1, 0);
    repeat (3) cycle(0, 0, 1, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0, 1, 0);
    check_eq("t5_stall", stall_cycles, 3);
    check_eq("t5_latency", bus.rec_latency, 4);

    // Timestamp wrap, finish with one outstanding, then reset while busy.
    cycle(0, 0, 0, 1, 0, 1, 1);
    idle_until(250);
    cycle(1, 1, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 1, 0);
    idle_until(4);
    cycle(0, 0, 1, 1, 0, 0, 0);
    check_eq("t6_latency", bus.rec_latency, 10);
    check_eq("t6_not_flushed", flushed, 0);
    idle(1);
    check_eq("t6_flushed", flushed, 1);
    cycle(0, 0, 0, 1, 0, 1, 1);
    cycle(1, 1, 0, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 1, 1);
    check_eq("t6_reset_outstanding", outstanding, 0);
    check_eq("t6_reset_busy", busy_cycles, 0);

    // Randomized traffic; long first run exercises counter saturation.
    cycle(0, 0, 0, 1, 0, 1, 1);
    random_run(1500, 0);
    drain();
    for (int r = 0; r < 2; r++) begin
      cycle(0, 0, 0, 1, 0, 1, 1);
      random_run(700, 1);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
